// File: rtl/oam_dma_bus_arbiter_if.sv
// Bus bundle between the SM83 core, the external memory bus and OAM.
// The arbiter attaches through the slave modport.
interface oam_dma_bus_arbiter_if;
    logic        DMA_START;
    logic [7:0]  DMA_PAGE;
    logic [15:0] CPU_A;
    logic        CPU_RD;
    logic        CPU_WR;
    logic [7:0]  CPU_DO;
    logic [7:0]  CPU_DI;
    logic [15:0] BUS_A;
    logic        BUS_RD;
    logic        BUS_WR;
    logic [7:0]  BUS_DO;
    logic [7:0]  BUS_DI;
    logic [7:0]  OAM_A;
    logic [7:0]  OAM_D;
    logic        OAM_WE;
    logic        DMA_ACTIVE;

    modport slave (
        input  DMA_START, DMA_PAGE, CPU_A, CPU_RD, CPU_WR, CPU_DO, BUS_DI,
        output CPU_DI, BUS_A, BUS_RD, BUS_WR, BUS_DO, OAM_A, OAM_D, OAM_WE, DMA_ACTIVE
    );

    modport master (
        output DMA_START, DMA_PAGE, CPU_A, CPU_RD, CPU_WR, CPU_DO, BUS_DI,
        input  CPU_DI, BUS_A, BUS_RD, BUS_WR, BUS_DO, OAM_A, OAM_D, OAM_WE, DMA_ACTIVE
    );
endinterface

// File: rtl/oam_dma_bus_arbiter.sv
// Shares the external memory bus between the CPU and the OAM DMA engine,
// which copies one byte per M-cycle from {src,idx} into OAM.
module oam_dma_bus_arbiter #(
    parameter int MCYCLE_CLKS = 4,
    parameter int XFER_LEN    = 160,
    parameter int START_DELAY = 1,
    parameter int ECHO_REMAP  = 1
) (
    input  logic                  CLK,
    input  logic                  nRESET,
    oam_dma_bus_arbiter_if.slave  bus
);
    localparam int          PW         = (MCYCLE_CLKS > 2) ? $clog2(MCYCLE_CLKS) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(MCYCLE_CLKS - 1);
    localparam logic [7:0]  LAST_IDX   = 8'(XFER_LEN - 1);
    localparam logic [3:0]  DLY_INIT   = 4'(START_DELAY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_XFER
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q;
    logic [7:0]    idx_q, idx_d;
    logic [3:0]    dly_q, dly_d;
    logic [7:0]    src_q, src_d;
    logic [7:0]    oam_a_q, oam_a_d;
    logic [7:0]    oam_d_q, oam_d_d;
    logic          oam_we_q, oam_we_d;

    logic          boundary;
    logic [7:0]    src_start;

    assign boundary  = (phase_q == PHASE_LAST);
    // Echo RAM mirrors C000-DDFF, so pages E0 and up are fetched from the real RAM.
    assign src_start = ((ECHO_REMAP != 0) && (bus.DMA_PAGE >= 8'hE0)) ?
                       (bus.DMA_PAGE - 8'h20) : bus.DMA_PAGE;

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            phase_q  <= '0;
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            dly_q    <= '0;
            src_q    <= '0;
            oam_a_q  <= '0;
            oam_d_q  <= '0;
            oam_we_q <= 1'b0;
        end else begin
            phase_q  <= boundary ? '0 : phase_q + 1'b1;
            state_q  <= state_d;
            idx_q    <= idx_d;
            dly_q    <= dly_d;
            src_q    <= src_d;
            oam_a_q  <= oam_a_d;
            oam_d_q  <= oam_d_d;
            oam_we_q <= oam_we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        dly_d    = dly_q;
        src_d    = src_q;
        oam_a_d  = oam_a_q;
        oam_d_d  = oam_d_q;
        oam_we_d = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (boundary) begin
                    if (dly_q != 4'd0) begin
                        dly_d = dly_q - 4'd1;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (boundary) begin
                    oam_a_d  = idx_q;
                    oam_d_d  = bus.BUS_DI;
                    oam_we_d = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            default: ;
        endcase
        // A start strobe always wins, but the byte captured on this edge above still lands.
        if (bus.DMA_START) begin
            state_d = ST_ARM;
            idx_d   = 8'd0;
            dly_d   = DLY_INIT;
            src_d   = src_start;
        end
    end

    logic        xfer;
    logic        active;
    logic        cpu_ext;
    logic        cpu_oam;
    logic [15:0] bus_a_c;
    logic        bus_rd_c;
    logic        bus_wr_c;
    logic [7:0]  bus_do_c;
    logic [7:0]  cpu_di_c;

    assign xfer    = (state_q == ST_XFER);
    assign active  = (state_q != ST_IDLE);
    assign cpu_ext = (bus.CPU_A < 16'hFF00);
    assign cpu_oam = (bus.CPU_A >= 16'hFE00) && (bus.CPU_A <= 16'hFE9F);

    always_comb begin
        bus_a_c  = bus.CPU_A;
        bus_rd_c = 1'b0;
        bus_wr_c = 1'b0;
        bus_do_c = bus.CPU_DO;
        cpu_di_c = bus.BUS_DI;
        if (xfer) begin
            bus_a_c  = {src_q, idx_q};
            bus_rd_c = 1'b1;
            bus_do_c = 8'h00;
            if (cpu_ext) begin
                cpu_di_c = 8'hFF;
            end
        end else if (cpu_ext) begin
            bus_rd_c = bus.CPU_RD;
            if (active && cpu_oam) begin
                cpu_di_c = 8'hFF;
            end else begin
                bus_wr_c = bus.CPU_WR;
            end
        end
        if (!nRESET) begin
            bus_rd_c = 1'b0;
            bus_wr_c = 1'b0;
        end
    end

    assign bus.BUS_A      = bus_a_c;
    assign bus.BUS_RD     = bus_rd_c;
    assign bus.BUS_WR     = bus_wr_c;
    assign bus.BUS_DO     = bus_do_c;
    assign bus.CPU_DI     = cpu_di_c;
    assign bus.OAM_A      = oam_a_q;
    assign bus.OAM_D      = oam_d_q;
    assign bus.OAM_WE     = oam_we_q;
    assign bus.DMA_ACTIVE = active;
endmodule

// File: tb/tb_oam_dma_bus_arbiter.sv
// Random and directed stimulus on two arbiters (echo remap on / off) checked
// against a boundary-counting transfer model kept in the bench.
module tb_oam_dma_bus_arbiter;
    localparam int M   = 4;
    localparam int LEN = 160;
    localparam int SD  = 1;

    logic clk;
    logic nrst;
    logic start;
    logic [7:0]  page;
    logic [15:0] cpu_a;
    logic cpu_rd, cpu_wr;
    logic [7:0]  cpu_do;
    logic fixed_en;
    logic [7:0]  fixed_v;

    oam_dma_bus_arbiter_if if0 ();
    oam_dma_bus_arbiter_if if1 ();

    oam_dma_bus_arbiter #(.MCYCLE_CLKS(M), .XFER_LEN(LEN), .START_DELAY(SD), .ECHO_REMAP(0)) dut0 (
        .CLK(clk), .nRESET(nrst), .bus(if0.slave));
    oam_dma_bus_arbiter #(.MCYCLE_CLKS(M), .XFER_LEN(LEN), .START_DELAY(SD), .ECHO_REMAP(1)) dut1 (
        .CLK(clk), .nRESET(nrst), .bus(if1.slave));

    assign if0.DMA_START = start;   assign if1.DMA_START = start;
    assign if0.DMA_PAGE  = page;    assign if1.DMA_PAGE  = page;
    assign if0.CPU_A     = cpu_a;   assign if1.CPU_A     = cpu_a;
    assign if0.CPU_RD    = cpu_rd;  assign if1.CPU_RD    = cpu_rd;
    assign if0.CPU_WR    = cpu_wr;  assign if1.CPU_WR    = cpu_wr;
    assign if0.CPU_DO    = cpu_do;  assign if1.CPU_DO    = cpu_do;
    // Memory responder: byte at {hi,lo} is lo^hi^65 (so page C0 gives idx^A5).
    assign if0.BUS_DI = fixed_en ? fixed_v : (if0.BUS_A[7:0] ^ if0.BUS_A[15:8] ^ 8'h65);
    assign if1.BUS_DI = fixed_en ? fixed_v : (if1.BUS_A[7:0] ^ if1.BUS_A[15:8] ^ 8'h65);

    logic [15:0] o_bus_a[2];
    logic        o_bus_rd[2], o_bus_wr[2], o_we[2], o_act[2];
    logic [7:0]  o_bus_do[2], o_cpu_di[2], o_oam_a[2], o_oam_d[2], o_bus_di[2];
    assign o_bus_a[0] = if0.BUS_A;   assign o_bus_a[1] = if1.BUS_A;
    assign o_bus_rd[0] = if0.BUS_RD; assign o_bus_rd[1] = if1.BUS_RD;
    assign o_bus_wr[0] = if0.BUS_WR; assign o_bus_wr[1] = if1.BUS_WR;
    assign o_bus_do[0] = if0.BUS_DO; assign o_bus_do[1] = if1.BUS_DO;
    assign o_cpu_di[0] = if0.CPU_DI; assign o_cpu_di[1] = if1.CPU_DI;
    assign o_oam_a[0] = if0.OAM_A;   assign o_oam_a[1] = if1.OAM_A;
    assign o_oam_d[0] = if0.OAM_D;   assign o_oam_d[1] = if1.OAM_D;
    assign o_we[0] = if0.OAM_WE;     assign o_we[1] = if1.OAM_WE;
    assign o_act[0] = if0.DMA_ACTIVE; assign o_act[1] = if1.DMA_ACTIVE;
    assign o_bus_di[0] = if0.BUS_DI; assign o_bus_di[1] = if1.BUS_DI;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: a transfer is busy from the start strobe; it skips
    // SD+1 M-cycle boundaries, then each boundary lands one byte.
    logic       m_busy;
    int         m_wait, m_idx, m_phase;
    logic [7:0] m_src[2];
    logic       m_we;
    logic [7:0] m_oa;
    logic [7:0] m_od[2];

    function automatic logic [7:0] mem_byte(input logic [7:0] hi, input logic [7:0] lo);
        return lo ^ hi ^ 8'h65;
    endfunction

    task automatic model_step();
        logic bnd;
        if (!nrst) begin
            m_busy = 1'b0; m_wait = 0; m_idx = 0; m_phase = 0;
            m_we = 1'b0; m_oa = 8'h00; m_od[0] = 8'h00; m_od[1] = 8'h00;
        end else begin
            bnd  = (m_phase == M - 1);
            m_we = 1'b0;
            if (m_busy && bnd) begin
                if (m_wait == 0) begin
                    m_we = 1'b1;
                    m_oa = 8'(m_idx);
                    for (int k = 0; k < 2; k++) m_od[k] = mem_byte(m_src[k], 8'(m_idx));
                    if (m_idx == LEN - 1) begin
                        m_busy = 1'b0;
                        $display("transfer done: src=%h/%h bytes=%0d", m_src[0], m_src[1], LEN);
                    end else begin
                        m_idx++;
                    end
                end else begin
                    m_wait--;
                end
            end
            if (start) begin
                m_busy = 1'b1; m_idx = 0; m_wait = SD + 1;
                m_src[0] = page;
                m_src[1] = (page >= 8'hE0) ? page - 8'h20 : page;
                $display("dma start: page=%h", page);
            end
            m_phase = (m_phase + 1) % M;
        end
    endtask

    task automatic check_all();
        logic xf, in_oam, ext, exp_wr;
        xf     = m_busy && (m_wait == 0);
        in_oam = (cpu_a >= 16'hFE00) && (cpu_a <= 16'hFE9F);
        ext    = (cpu_a < 16'hFF00);
        for (int k = 0; k < 2; k++) begin
            chk("dma_active", o_act[k], m_busy);
            chk("oam_we", o_we[k], m_we);
            if (m_we || !nrst) begin
                chk("oam_a", o_oam_a[k], m_oa);
                chk("oam_d", o_oam_d[k], m_od[k]);
            end
            if (!nrst) begin
                chk("rst_bus_rd", o_bus_rd[k], 1'b0);
                chk("rst_bus_wr", o_bus_wr[k], 1'b0);
            end else if (xf) begin
                chk("xfer_bus_a", o_bus_a[k], {m_src[k], 8'(m_idx)});
                chk("xfer_bus_rd", o_bus_rd[k], 1'b1);
                chk("xfer_bus_wr", o_bus_wr[k], 1'b0);
                chk("xfer_bus_do", o_bus_do[k], 8'h00);
                chk("xfer_cpu_di", o_cpu_di[k], ext ? 8'hFF : o_bus_di[k]);
            end else if (ext) begin
                exp_wr = cpu_wr && !(m_busy && in_oam);
                chk("cpu_bus_a", o_bus_a[k], cpu_a);
                if (!(m_busy && in_oam)) chk("cpu_bus_rd", o_bus_rd[k], cpu_rd);
                chk("cpu_bus_wr", o_bus_wr[k], exp_wr);
                if (exp_wr) chk("cpu_bus_do", o_bus_do[k], cpu_do);
                chk("cpu_di", o_cpu_di[k], (m_busy && in_oam) ? 8'hFF : o_bus_di[k]);
            end else begin
                chk("mmio_bus_rd", o_bus_rd[k], 1'b0);
                chk("mmio_bus_wr", o_bus_wr[k], 1'b0);
                chk("mmio_cpu_di", o_cpu_di[k], o_bus_di[k]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic start_dma(input logic [7:0] p);
        page = p; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (m_busy && n < 3000) begin tick(); n++; end
        chk(tag, {31'd0, m_busy}, 32'd0);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        int n;
        int r;
        nrst = 1'b0; start = 1'b0; page = 8'h00;
        cpu_a = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_do = 8'h00;
        fixed_en = 1'b1; fixed_v = 8'h5A;
        m_busy = 1'b0; m_wait = 0; m_idx = 0; m_phase = 0; m_we = 1'b0;
        m_oa = 8'h00; m_od[0] = 8'h00; m_od[1] = 8'h00; m_src[0] = 8'h00; m_src[1] = 8'h00;
        repeat (3) tick();

        // Idle CPU read forwarded
        nrst = 1'b1; cpu_a = 16'h1234; cpu_rd = 1'b1;
        repeat (3) tick();
        chk("t1_cpu_di", o_cpu_di[1], 8'h5A);
        chk("t1_bus_a", o_bus_a[1], 16'h1234);
        cpu_a = 16'hFF80;
        tick();
        fixed_en = 1'b0; cpu_a = 16'h0000; cpu_rd = 1'b0;

        // Full transfer from C0 with CPU reads to RAM, OAM and HRAM during it
        start_dma(8'hC0);
        n = 0;
        while (m_busy && n < 3000) begin
            case (n % 3)
                0: cpu_a = 16'hC100;
                1: cpu_a = 16'hFE10;
                default: cpu_a = 16'hFF80;
            endcase
            cpu_rd = 1'b1; cpu_wr = (n % 5) == 0; cpu_do = 8'(n);
            tick(); n++;
        end
        chk("t2_timeout", {31'd0, m_busy}, 32'd0);
        cpu_a = 16'h0000; cpu_rd = 1'b0; cpu_wr = 1'b0;
        repeat (4) tick();

        // Echo page: remapped on dut1, literal on dut0
        start_dma(8'hE1);
        wait_idle("t4_timeout");

        // Restart on the boundary edge that writes byte 0x40
        start_dma(8'hC0);
        n = 0;
        while (!(m_busy && m_wait == 0 && m_idx == 'h40 && m_phase == M - 1) && n < 3000) begin
            tick(); n++;
        end
        chk("t5_reach", {31'd0, m_busy}, 32'd1);
        start_dma(8'hD0);
        chk("t5_last_oam_a", o_oam_a[1], 8'h40);
        wait_idle("t5_timeout");

        // Reset mid-transfer
        start_dma(8'h80);
        n = 0;
        while (!(m_busy && m_wait == 0 && m_idx == 'h20) && n < 3000) begin tick(); n++; end
        nrst = 1'b0; cpu_a = 16'h4000; cpu_rd = 1'b1;
        repeat (2) tick();
        nrst = 1'b1;
        repeat (8) tick();

        // Random traffic
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: cpu_a = 16'($urandom);
                1: cpu_a = 16'hFE00 + 16'($urandom_range(0, 'hBF));
                2: cpu_a = 16'hFF00 | 16'($urandom_range(0, 255));
                default: cpu_a = 16'($urandom_range(0, 'hFDFF));
            endcase
            cpu_rd = 1'($urandom); cpu_wr = 1'($urandom); cpu_do = 8'($urandom);
            nrst = ($urandom_range(0, 1999) != 0);
            page = 8'($urandom);
            start = ($urandom_range(0, 299) == 0);
            tick();
            start = 1'b0;
        end
        nrst = 1'b1;
        wait_idle("rand_timeout");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
